// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: valid/ready front end that drives a combinational ALU, holds
// its inputs for an opcode-dependent number of cycles, then returns the result.
module alu_issue_ctrl #(
  parameter int WIDTH     = 8,
  parameter int SUM_WAIT  = 15,
  parameter int SUB_WAIT  = 10,
  parameter int MULT_WAIT = 7,
  parameter int DEF_WAIT  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_i1,
  input  logic [WIDTH-1:0] req_i2,
  input  logic [1:0]       req_opcode,
  output logic [WIDTH-1:0] alu_i1,
  output logic [WIDTH-1:0] alu_i2,
  output logic [1:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_o1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_o1,
  output logic [1:0]       rsp_opcode,
  output logic             busy
);
  localparam int MAX_A = SUM_WAIT > SUB_WAIT ? SUM_WAIT : SUB_WAIT;
  localparam int MAX_B = MULT_WAIT > DEF_WAIT ? MULT_WAIT : DEF_WAIT;
  localparam int MAX_W = MAX_A > MAX_B ? MAX_A : MAX_B;
  localparam int CW    = MAX_W > 1 ? $clog2(MAX_W) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt, w_load;
  logic             w_accept, w_done;
  logic [WIDTH-1:0] r_alu_i1, r_alu_i2, r_rsp_o1;
  logic [1:0]       r_alu_opcode, r_rsp_opcode;

  assign alu_i1     = r_alu_i1;
  assign alu_i2     = r_alu_i2;
  assign alu_opcode = r_alu_opcode;
  assign rsp_o1     = r_rsp_o1;
  assign rsp_opcode = r_rsp_opcode;

  // In RESP, req_ready follows rsp_ready so a new request can overlap the response handshake
  always_comb begin
    req_ready = (r_state == IDLE) || (r_state == RESP && rsp_ready);
    rsp_valid = r_state == RESP;
    busy      = r_state != IDLE;
    w_accept  = req_valid && req_ready;
    w_done    = r_state == WAIT && r_cnt == '0;
    w_load    = req_opcode == 2'b00 ? CW'(SUM_WAIT - 1) :
                req_opcode == 2'b01 ? CW'(SUB_WAIT - 1) :
                req_opcode == 2'b10 ? CW'(MULT_WAIT - 1) : CW'(DEF_WAIT - 1);
    w_next    = r_state == IDLE ? (w_accept ? WAIT : IDLE) :
                r_state == WAIT ? (w_done ? RESP : WAIT) :
                r_state == RESP ? (w_accept ? WAIT : rsp_ready ? IDLE : RESP) : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_alu_i1     <= '0;
      r_alu_i2     <= '0;
      r_alu_opcode <= 2'b11;
      r_rsp_o1     <= '0;
      r_rsp_opcode <= 2'b00;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_alu_i1     <= req_i1;
        r_alu_i2     <= req_i2;
        r_alu_opcode <= req_opcode;
        r_cnt        <= w_load;
      end else if (r_state == WAIT && !w_done) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_done) begin
        r_rsp_o1     <= alu_o1;
        r_rsp_opcode <= r_alu_opcode;
      end
    end
  end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential front end for the combinational `ALU` block. It accepts operand/opcode requests over a valid/ready handshake and drives them onto the ALU inputs. It holds those inputs stable for an opcode-dependent number of clock cycles matching the ALU's specified path delays, then samples `o1` and returns the result over a second valid/ready handshake. It sits between any requester (testbench, sequencer) and the ALU instance, so ALU outputs are never sampled before the path delay has elapsed.

## Interface
- `WIDTH`, 8: operand/result width; must equal ALU data width.
- `SUM_WAIT`, 15: cycles inputs are held before sampling for opcode 2'b00.
- `SUB_WAIT`, 10: cycles held for opcode 2'b01.
- `MULT_WAIT`, 7: cycles held for opcode 2'b10.
- `DEF_WAIT`, 1: cycles held for opcode 2'b11.
- All `*_WAIT` values are ≥1, and each is ≥ ceil(ALU path delay / clock period). Defaults assume a 1 ns clock (`timescale 1ns/1ps`).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_i1`, `req_i2`  in  WIDTH  operands.
- `req_opcode`  in  2  operation code; encoding matches ALU `opcode`.
- `alu_i1`, `alu_i2`  out  WIDTH  registered drive to ALU `i1`/`i2`.
- `alu_opcode`  out  2  registered drive to ALU `opcode`.
- `alu_o1`  in  WIDTH  ALU result `o1`.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_o1`  out  WIDTH  captured result.
- `rsp_opcode`  out  2  opcode the result belongs to.
- `busy`  out  1  high in WAIT or RESP.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid && req_ready`: register `req_i1/i2/opcode` into `alu_i1/i2/opcode`.
  - Load the down-counter with the selected `*_WAIT` − 1, then go to WAIT.
- WAIT:
  - `req_ready`=0.
  - Counter decrements each edge.
  - On the edge where the counter is 0: register `alu_o1` into `rsp_o1`, register `alu_opcode` into `rsp_opcode`, and go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_o1`/`rsp_opcode` are held stable until the handshake.
  - `req_ready` = `rsp_ready`.
  - On `rsp_valid && rsp_ready` with no new request: go to IDLE.
  - If `req_valid` is also high in the same cycle: accept the new request as in IDLE and go directly to WAIT (back-to-back, no bubble).
- The ALU has no internal state, so a WAIT slot always yields the result of the operands currently being driven.
- `alu_i1/i2/opcode` change only on request acceptance or reset. They hold their last values in IDLE/RESP, so the ALU sees no spurious transitions.
- The counter is wide enough for max(`*_WAIT`) − 1: $clog2(max), minimum 1 bit.
- `busy` = (state != IDLE).
- The controller does not interpret result values; opcode 2'b11 simply returns whatever the ALU drives (0 for the current ALU).

## Timing
- Reset (synchronous, `rst`=1 at a rising edge), effective after that edge:
  - State = IDLE, counter = 0, `busy`=0.
  - `req_ready`=1, `rsp_valid`=0.
  - `rsp_o1`=0, `rsp_opcode`=0.
  - `alu_i1`=`alu_i2`=0, `alu_opcode`=2'b11.
- Reset mid-WAIT or mid-RESP aborts the operation. The pending result is discarded and never presented.
- `rst` overrides any handshake in the same cycle.
- Latency: request accepted at edge E0. ALU inputs update after E0. `alu_o1` is sampled at edge E0+W (W = selected wait). `rsp_valid` goes high after E0+W.
- ALU inputs are stable for exactly W clock periods before sampling.
- Request-to-response throughput: one result per W+1 cycles with `rsp_ready` held high (W in WAIT, 1 in RESP).
- `req_ready` in IDLE is a registered state decode. In RESP it is combinationally equal to `rsp_ready`; there is no other comb path from inputs to outputs.
- `req_*` inputs are ignored when not accepted. `rsp_ready` is ignored outside RESP.

## Test plan
- Reset then idle:
  - Stimulus: assert `rst` 2 cycles, release.
  - Response: `req_ready`=1, `rsp_valid`=0, `busy`=0, `alu_opcode`=2'b11, all data 0.
- SUM:
  - Stimulus: req i1=8'h12, i2=8'h34, opcode 2'b00, `rsp_ready`=1.
  - Response: `rsp_valid` rises 15 cycles after the accept edge; `rsp_o1`=8'h46, `rsp_opcode`=2'b00.
- SUB and MULT wrap:
  - SUB: i1=8'h05, i2=8'h07 → `rsp_o1`=8'hFE after 10 cycles.
  - MULT: i1=8'h10, i2=8'h11 → `rsp_o1`=8'h10 (low 8 bits of 0x110) after 7 cycles.
- Default opcode:
  - Stimulus: opcode 2'b11, i1=8'hAA, i2=8'h55.
  - Response: `rsp_o1`=8'h00 after 1 cycle.
- Backpressure and back-to-back:
  - Stimulus: hold `rsp_ready`=0 for 5 cycles in RESP.
  - Response: `rsp_o1` is stable and `req_ready`=0 throughout.
  - Stimulus: raise `rsp_ready` with a new SUB request in the same cycle.
  - Response: the new request is accepted on that edge; next `rsp_valid` rises 10 cycles later.
- Reset mid-operation:
  - Stimulus: pulse `rst` in the 6th WAIT cycle of a SUM.
  - Response: no `rsp_valid` ever for that request; IDLE with reset values on the next cycle.
